sid_bus_sequencer: RTL

Bus-side initiator for the SID emulation block. It accepts timestamped register-write commands from the host (soft CPU or SID-file player) and buffers them in a FIFO. It replays each command as a single-cycle chip-select/write strobe on the SID register interface, after a programmable delay counted in C64 PHI2 ticks. This gives cycle-paced SID playback without the host servicing each write in real time.

---
 rtl/sid_bus_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/sid_bus_sequencer.sv
// sid_bus_sequencer
//   Bus-side initiator for the SID emulation block. Host register writes are
//   queued with a per-command delay in C64 ticks. Each command is replayed as a
//   one-cycle cs/we strobe on the SID register port once its delay has elapsed.
//
// Ports
//   clk_sys, rst_n          : system clock, async active-low reset
//   cmd_valid/cmd_ready     : host command handshake
//   cmd_addr/data/delay     : SID register, value, C64 ticks to wait after dequeue
//   enable                  : 0 pauses dequeue and delay countdown
//   flush                   : drop the queued commands and any pending command
//   sid_cs/we/addr/wdata    : SID register interface
//   busy                    : command pending, in flight or queued
//   fifo_level              : queued entries, 0..FIFO_DEPTH
module sid_bus_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TICK_DIV   = 50
) (
  input  logic                          clk_sys,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [4:0]                    cmd_addr,
  input  logic [7:0]                    cmd_data,
  input  logic [15:0]                   cmd_delay,
  input  logic                          enable,
  input  logic                          flush,
  output logic                          sid_cs,
  output logic                          sid_we,
  output logic [4:0]                    sid_addr,
  output logic [7:0]                    sid_wdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [7:0]  data;
    logic [15:0] delay;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_t;

  // Free-running C64 tick prescaler; never gated by enable or flush.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // Command FIFO. Storage is not reset; only pointers and level are.
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  state_t        state;

  assign cmd_ready = (fifo_level < LW'(FIFO_DEPTH)) && !flush;
  assign push      = cmd_valid && cmd_ready;
  // Level is updated on the push edge, so a fresh entry is only seen a cycle later.
  assign pop       = (state == IDLE) && enable && (fifo_level != '0) && !flush;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= '{addr: cmd_addr, data: cmd_data, delay: cmd_delay};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Sequencer. cs/we are decoded from the next state so the strobe is a clean
  // registered pulse for exactly the WRITE cycle.
  logic [15:0] delay_cnt;
  logic [4:0]  hold_addr;
  logic [7:0]  hold_data;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      sid_cs    <= 1'b0;
      sid_we    <= 1'b0;
      sid_addr  <= '0;
      sid_wdata <= '0;
    end else begin
      sid_cs <= 1'b0;
      sid_we <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            hold_addr <= head.addr;
            hold_data <= head.data;
            delay_cnt <= head.delay;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            // Pending command is discarded without a write.
            delay_cnt <= '0;
            state     <= IDLE;
          end else if (delay_cnt == '0) begin
            state     <= WRITE;
            sid_cs    <= 1'b1;
            sid_we    <= 1'b1;
            sid_addr  <= hold_addr;
            sid_wdata <= hold_data;
          end else if (enable && tick) begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        // A started strobe always completes, regardless of enable or flush.
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE) || (fifo_level != '0);

endmodule
